// File: rtl/dnn_dot_engine.sv
// Avalon-MM dot-product engine: CSR slave for job setup, read-only master that
// streams interleaved weight/activation words and accumulates a Q16.16 sum.
module dnn_dot_engine #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [31:0]       master_writedata
);

  typedef enum logic [2:0] {
    IDLE, RD_W, WAIT_W, RD_A, WAIT_A, MAC, FIN
  } state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0] w_base, a_base, wptr, aptr;
  logic [31:0]       bias, result, acc;
  logic [LEN_W-1:0]  len, cnt;
  logic              relu, done;
  logic signed [31:0] w_reg, a_reg;
  logic signed [63:0] prod;
  logic [31:0]       prod_q;
  logic [LEN_W:0]    cnt_inc;
  logic              busy, start, last;
  logic [31:0]       rdata;

  assign busy    = (state != IDLE);
  assign start   = slave_write && (slave_address == 4'd0) && !busy;
  assign prod    = w_reg * a_reg;
  // Arithmetic shift then truncate keeps prod[47:16]: the Q16.16 product.
  assign prod_q  = 32'(prod >>> 16);
  assign cnt_inc = {1'b0, cnt} + (LEN_W+1)'(1);
  assign last    = (cnt_inc >= {1'b0, len});

  assign slave_waitrequest = 1'b0;
  assign master_write      = 1'b0;
  assign master_writedata  = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt            = state;
    master_read    = 1'b0;
    master_address = '0;
    case (state)
      IDLE:   if (start) nxt = (len == '0) ? FIN : RD_W;
      RD_W: begin
        master_read    = 1'b1;
        master_address = wptr;
        if (!master_waitrequest) nxt = WAIT_W;
      end
      WAIT_W: if (master_readdatavalid) nxt = RD_A;
      RD_A: begin
        master_read    = 1'b1;
        master_address = aptr;
        if (!master_waitrequest) nxt = WAIT_A;
      end
      WAIT_A: if (master_readdatavalid) nxt = MAC;
      MAC:    nxt = last ? FIN : RD_W;
      FIN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_base <= '0;
      a_base <= '0;
      bias   <= '0;
      len    <= '0;
      relu   <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      wptr   <= '0;
      aptr   <= '0;
      w_reg  <= '0;
      a_reg  <= '0;
    end else begin
      // Configuration is frozen for the whole job.
      if (slave_write && !busy) begin
        case (slave_address)
          4'd2: w_base <= ADDR_W'(slave_writedata);
          4'd3: a_base <= ADDR_W'(slave_writedata);
          4'd4: bias   <= slave_writedata;
          4'd5: len    <= slave_writedata[LEN_W-1:0];
          4'd6: relu   <= slave_writedata[0];
          default: ;
        endcase
      end
      if (start) begin
        done <= 1'b0;
        acc  <= bias;
        cnt  <= '0;
        wptr <= w_base;
        aptr <= a_base;
      end
      case (state)
        WAIT_W: if (master_readdatavalid) w_reg <= master_readdata;
        WAIT_A: if (master_readdatavalid) a_reg <= master_readdata;
        MAC: begin
          acc  <= acc + prod_q;
          cnt  <= cnt_inc[LEN_W-1:0];
          wptr <= wptr + ADDR_W'(4);
          aptr <= aptr + ADDR_W'(4);
        end
        FIN: begin
          result <= (relu && acc[31]) ? '0 : acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (slave_address)
      4'd0: rdata = {30'b0, done, busy};
      4'd1: rdata = result;
      4'd2: rdata = 32'(w_base);
      4'd3: rdata = 32'(a_base);
      4'd4: rdata = bias;
      4'd5: rdata = 32'(len);
      4'd6: rdata = {31'b0, relu};
      default: rdata = '0;
    endcase
  end

  assign slave_readdata = slave_read ? rdata : '0;

endmodule

// File: doc/dnn_dot_engine.md
Name: dnn_dot_engine

Overview:
Avalon-MM accelerator component instantiated inside dnn_accel_system, next to the SDRAM controller and the hex PIO. Software programs base addresses, length, bias and a ReLU enable through a CSR slave, then writes start. A master port streams weight and activation words from SDRAM and accumulates a signed Q16.16 dot product plus bias, with optional ReLU. Software polls for completion and reads the result, which it then drives to the hex display.

Parameters:
ADDR_W, 32, master address width (byte addresses)
LEN_W, 16, width of the element-count register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
slave_waitrequest  out  1  constant 0
slave_address  in  4  CSR word offset
slave_read  in  1  CSR read strobe
slave_readdata  out  32  CSR read data; combinational, zero-latency
slave_write  in  1  CSR write strobe
slave_writedata  in  32  CSR write data
master_waitrequest  in  1  SDRAM side stall
master_address  out  ADDR_W  byte address of the current read
master_read  out  1  read request
master_readdata  in  32  returned word
master_readdatavalid  in  1  master_readdata is valid
master_write  out  1  tied 0
master_writedata  out  32  tied 0

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - All CSRs return to 0 and the FSM returns to IDLE.
  - master_read=0, master_address=0, busy=0.
  - Assertion mid-operation aborts the job; no partial result is kept.
- CSR map (word offsets):
  - 0 CTRL: write any value = start; read returns bit0=busy, bit1=done_sticky.
  - 1 RESULT: read-only.
  - 2 W_BASE: weight base address.
  - 3 A_BASE: activation base address.
  - 4 BIAS: Q16.16.
  - 5 LEN: element count, low LEN_W bits.
  - 6 RELU: bit0 only.
  - Other offsets read 0 and ignore writes.
- Writes to offsets 2-6 or CTRL while busy=1 are ignored.
- Start while idle does the following:
  - Sets busy and clears done_sticky.
  - Sets acc=BIAS, i=0, wptr=W_BASE, aptr=A_BASE.
- FSM: IDLE -> RD_W -> WAIT_W -> RD_A -> WAIT_A -> MAC -> (RD_W if i<LEN, else FIN) -> IDLE.
  - RD_W / RD_A: master_read=1 with master_address=wptr or aptr, held stable while master_waitrequest=1. Leave the state the first cycle master_read=1 and master_waitrequest=0.
  - WAIT_W / WAIT_A: master_read=0. Capture master_readdata on master_readdatavalid, which may arrive 1 or more cycles after acceptance. At most one read outstanding.
  - MAC: prod = signed(w)*signed(a), 64-bit; acc += prod[47:16]. Addition is 32-bit two's complement and wraps; no saturation. Then i++, wptr+=4, aptr+=4.
  - FIN: RESULT = (RELU && acc[31]) ? 0 : acc. busy=0, done_sticky=1.
- LEN=0: go straight from start to FIN with no master reads; RESULT = BIAS, ReLU applied.
- Start-to-busy latency is 1 cycle. With zero waitrequest and readdatavalid one cycle after acceptance, each element takes 5 cycles.
- RESULT holds its value until the next FIN; it is readable at any time.

Test Plan:
- Basic dot product: W=[0x00010000, 0x00020000, 0xFFFF8000], A=[0x00030000, 0x00008000, 0x00040000], BIAS=0x00004000, LEN=3, RELU=0 -> exactly 6 master reads, interleaved W0,A0,W1,A1,W2,A2. Ends with RESULT=0x00024000 (2.25) and CTRL=0x2.
- ReLU clamp: same data with BIAS=0xFFFB0000 (-5.0). RELU=0 -> RESULT=0xFFFD0000. RELU=1 -> RESULT=0x00000000.
- LEN=0, BIAS=0x12345678 -> no master_read pulse; RESULT=0x12345678 within 3 cycles; done_sticky=1.
- Random master_waitrequest (50%) and readdatavalid delays of 1-5 cycles, LEN=8 -> master_address and master_read stable throughout every stall. RESULT matches the reference model, and there is never more than one outstanding read.
- Write W_BASE=0xDEAD and start while busy -> both ignored; the job completes with the original addresses and result.
- Assert rst_n low during WAIT_A of element 2 -> master_read=0 and all CSRs 0 immediately. After release, a fresh job computes correctly.
